// File: rtl/sine_pwm_player.sv
// sine_pwm_player
// Walks a 256 x 11-bit sine LUT with a programmable address step, issuing one
// registered read per PWM period. It plays each fetched sample as a
// single-bit PWM with a period of 2^DATA_W clocks.
//
// Ports
//   clk          system clock
//   resetn       synchronous active-low reset (overrides en)
//   en           run enable; low = counter cleared, output quiet
//   step         LUT address increment, sampled at each period wrap
//   mem_ena      LUT read enable, one-cycle pulse per period
//   mem_wea      LUT write enable, tied low
//   mem_addr     LUT address, changes only at period wrap
//   mem_dout     LUT read data, valid RD_LAT clocks after mem_ena
//   pwm_out      registered PWM output
//   sample_tick  high for the first cycle a new duty value is in effect
//   pwm_out_n    registered complement of pwm_out (SINE_PWM_COMPL_EN only)
//
// Optional feature macro: SINE_PWM_COMPL_EN
module sine_pwm_player #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 11,
  parameter int unsigned RD_LAT = 1   // 1 or 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [ADDR_W-1:0] step,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              pwm_out,
  output logic              sample_tick
`ifdef SINE_PWM_COMPL_EN
  ,
  output logic              pwm_out_n
`endif
);

  // The fetch FSM is evaluated one cycle ahead of the READ cycle, so the
  // transition fires while cnt is one below FETCH_AT (2^DATA_W - 4). That
  // makes READ coincide with cnt = FETCH_AT.
  localparam logic [DATA_W-1:0] CNT_LAST  = '1;
  localparam logic [DATA_W-1:0] PRE_FETCH = CNT_LAST - DATA_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_duty;
  logic [DATA_W-1:0]   r_next_sample;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_pwm;
  logic                r_tick;
  logic                w_wrap;
  logic                w_capture;
  logic                w_pwm_d;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_cnt == PRE_FETCH) w_state_next = S_READ;
      S_READ:    w_state_next = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    // Disable aborts any fetch in flight.
    if (!en) w_state_next = S_IDLE;
  end

  assign w_wrap    = en && (r_cnt == CNT_LAST);
  assign w_capture = en && (r_state == S_CAPTURE);
  assign w_pwm_d   = en && (r_cnt < r_duty);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_duty        <= '0;
      r_next_sample <= '0;
      r_addr        <= '0;
      r_pwm         <= 1'b0;
      r_tick        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pwm   <= w_pwm_d;
      if (!en) begin
        // Address and fetched sample are held across a disable.
        r_cnt  <= '0;
        r_duty <= '0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + DATA_W'(1);
        r_tick <= w_wrap;
        if (w_wrap) begin
          r_duty <= r_next_sample;
          r_addr <= r_addr + step;
        end
        if (w_capture) r_next_sample <= mem_dout;
      end
    end
  end

`ifdef SINE_PWM_COMPL_EN
  logic r_pwm_n;

  always_ff @(posedge clk) begin
    if (!resetn) r_pwm_n <= 1'b1;
    else         r_pwm_n <= ~w_pwm_d;
  end

  assign pwm_out_n = r_pwm_n;
`endif

  assign mem_ena     = (r_state == S_READ);
  assign mem_wea     = 1'b0;
  assign mem_addr    = r_addr;
  assign pwm_out     = r_pwm;
  assign sample_tick = r_tick;

endmodule

// File: tb/tb_sine_pwm_player.sv
// Self-checking bench for sine_pwm_player. Two instances (read latency 1 and
// 2) share the same stimulus and are checked against one period-level model.
module tb_sine_pwm_player;

  localparam int PER = 2048;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [7:0]  step;
  logic        ena  [2];
  logic        wea  [2];
  logic        pwm  [2];
  logic        tick [2];
  logic [7:0]  addr [2];
  logic [10:0] dout [2];
`ifdef SINE_PWM_COMPL_EN
  logic        pwm_n [2];
`endif

  always #5 clk = ~clk;

  sine_pwm_player #(.ADDR_W(8), .DATA_W(11), .RD_LAT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .en(en), .step(step),
    .mem_ena(ena[0]), .mem_wea(wea[0]), .mem_addr(addr[0]), .mem_dout(dout[0]),
    .pwm_out(pwm[0]), .sample_tick(tick[0])
`ifdef SINE_PWM_COMPL_EN
    , .pwm_out_n(pwm_n[0])
`endif
  );

  sine_pwm_player #(.ADDR_W(8), .DATA_W(11), .RD_LAT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .en(en), .step(step),
    .mem_ena(ena[1]), .mem_wea(wea[1]), .mem_addr(addr[1]), .mem_dout(dout[1]),
    .pwm_out(pwm[1]), .sample_tick(tick[1])
`ifdef SINE_PWM_COMPL_EN
    , .pwm_out_n(pwm_n[1])
`endif
  );

  // LUT models: data is only valid in the cycle the latency promises,
  // otherwise the bus carries junk so a mistimed capture is visible.
  logic [10:0] lut [256];
  logic        v2;
  logic [10:0] d2;

  always @(posedge clk) dout[0] <= ena[0] ? lut[addr[0]] : 11'($urandom);

  always @(posedge clk) begin
    v2      <= ena[1];
    d2      <= lut[addr[1]];
    dout[1] <= v2 ? d2 : 11'($urandom);
  end

  int n_pass = 0;
  int n_chk  = 0;

  // Period-level reference state.
  int m_addr;
  int m_duty;
  bit m_tick_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Entered at the negedge of a period's cnt=0 cycle; leaves at the negedge
  // of the next period's cnt=0 cycle (or just after the gating point).
  task automatic run_period(input int gate_at, input int chg_at,
                            input int chg_step, input string tag);
    int   hi [2];
    int   enac [2];
    int   err [2];
    logic e;
    for (int d = 0; d < 2; d++) begin
      hi[d] = 0; enac[d] = 0; err[d] = 0;
    end
    for (int c = 0; c < PER; c++) begin
      for (int d = 0; d < 2; d++) begin
        e = (c >= 1) && (c - 1 < m_duty);
        if (pwm[d] === 1'b1) hi[d]++;
        if (pwm[d] !== e) err[d]++;
        if (ena[d] === 1'b1) enac[d]++;
        if (ena[d] !== (c == 2044)) err[d]++;
        if (addr[d] !== m_addr[7:0]) err[d]++;
        if (wea[d] !== 1'b0) err[d]++;
        if (tick[d] !== (c == 0 && m_tick_first)) err[d]++;
`ifdef SINE_PWM_COMPL_EN
        if (pwm_n[d] !== ~pwm[d]) err[d]++;
`endif
      end
      if (c == gate_at) begin
        en = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("%s cycle errs dut%0d", tag, d), err[d], 0);
          chk($sformatf("%s pwm after gate dut%0d", tag, d), pwm[d], 0);
          chk($sformatf("%s ena after gate dut%0d", tag, d), ena[d], 0);
          chk($sformatf("%s addr held dut%0d", tag, d), addr[d], m_addr);
        end
        return;
      end
      if (c == chg_at) step = chg_step[7:0];
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s high cycles dut%0d", tag, d), hi[d], m_duty);
      chk($sformatf("%s ena pulses dut%0d", tag, d), enac[d], 1);
      chk($sformatf("%s cycle errs dut%0d", tag, d), err[d], 0);
    end
    // Wrap: the sample fetched from this period's address plays next.
    m_duty       = lut[m_addr];
    m_addr       = (m_addr + step) % 256;
    m_tick_first = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int q;
    resetn = 1'b0;
    en     = 1'b1;
    step   = 8'd1;
    for (int i = 0; i < 256; i++) lut[i] = 11'($urandom);
    lut[0] = 11'd1024;
    lut[1] = 11'd0;
    lut[2] = 11'd2047;
    lut[3] = 11'd2047;

    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("reset outputs dut%0d", d),
            {ena[d], wea[d], pwm[d], tick[d], addr[d]}, 0);
`ifdef SINE_PWM_COMPL_EN
        chk($sformatf("reset pwm_n dut%0d", d), pwm_n[d], 1);
`endif
      end
    end

    // This cycle is cnt=0 of the first period.
    resetn       = 1'b1;
    m_addr       = 0;
    m_duty       = 0;
    m_tick_first = 1'b0;

    run_period(-1, -1, 0, "p0");        // duty 0, fetches addr 0
    run_period(-1, -1, 0, "p1");        // duty 1024
    run_period(-1, -1, 0, "p2");        // duty 0
    run_period(-1, -1, 0, "p3");        // duty 2047
    run_period(2045, -1, 0, "p4gate");  // duty 2047, disabled mid-fetch

    q = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (pwm[d] !== 1'b0 || ena[d] !== 1'b0 || tick[d] !== 1'b0 ||
            addr[d] !== m_addr[7:0]) q++;
    end
    chk("disabled quiet", q, 0);

    // Re-enable: this cycle is cnt=0, duty 0, fetching the held address.
    en           = 1'b1;
    m_duty       = 0;
    m_tick_first = 1'b0;
    step         = 8'd250;
    run_period(-1, -1, 0, "r0");        // addr 4 -> 254
    step = 8'd3;
    run_period(-1, -1, 0, "r1");        // addr 254 -> 1
    for (int d = 0; d < 2; d++) chk($sformatf("wrap addr dut%0d", d), addr[d], 1);
    step = 8'd0;
    run_period(-1, -1, 0, "r2");        // step 0 holds the address
    run_period(-1, 1000, 7, "r3");      // mid-period step change
    repeat (4) begin
      step = 8'($urandom_range(0, 255));
      run_period(-1, int'($urandom_range(100, 2000)),
                 int'($urandom_range(0, 255)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sine_pwm_player.md
# sine_pwm_player

Consumer stage for the 256×11-bit sine lookup block memory. It walks the LUT address space with a programmable step and issues one registered read per PWM period. It then converts each 11-bit sample into a single-bit pulse-width-modulated output for the board's audio/filter pin. It replaces the free-running address stimulus used around the LUT with a cycle-exact fetch/play pipeline.

## Interface
- `ADDR_W`, 8, LUT address width (256 entries).
- `DATA_W`, 11, sample width; PWM period = 2^DATA_W clocks (2048).
- `RD_LAT`, 1, LUT read latency in clocks from the `mem_ena` cycle to valid `mem_dout`; legal values 1 or 2.

- `clk`  in  1  system clock (100 MHz).
- `resetn`  in  1  synchronous, active-low reset.
- `en`  in  1  run enable; low = stopped and output quiet.
- `step`  in  ADDR_W  address increment per PWM period; sets tone frequency.
- `mem_ena`  out  1  LUT read enable, one-cycle pulse per period.
- `mem_wea`  out  1  LUT write enable, tied 0.
- `mem_addr`  out  ADDR_W  LUT address, registered.
- `mem_dout`  in  DATA_W  LUT read data.
- `pwm_out`  out  1  PWM output, registered.
- `sample_tick`  out  1  one-cycle pulse when a new duty value takes effect.

## Operation
- Period counter `cnt`, DATA_W bits. Increments every cycle while `en`=1 and wraps 2^DATA_W−1 → 0.
- `pwm_out` is registered from (`cnt` < `duty`), unsigned compare.
  - `duty`=0 gives constant low.
  - `duty`=2047 gives high for 2047 of 2048 cycles.
- Fetch FSM states and transitions:
  - IDLE → READ when `cnt` = FETCH_AT = 2^DATA_W−4.
  - READ (exactly one cycle): `mem_ena`=1. Then → WAIT.
  - WAIT: lasts RD_LAT−1 cycles; zero cycles when RD_LAT=1.
  - CAPTURE: `next_sample` ← `mem_dout`, then → IDLE.
- On the wrap edge (`cnt` 2047 → 0):
  - `duty` ← `next_sample`
  - `mem_addr` ← `mem_addr` + `step`, modulo 2^ADDR_W; overflow is discarded.
  - `sample_tick` = 1 for the following cycle.
- Result: period k+1 plays the sample read from the address held during period k.
- `mem_addr` changes only on the wrap edge, so it is stable throughout each fetch.
- `step`=0 repeats the same sample, giving a DC level.
- `step` is sampled only at the wrap edge; changes mid-period take effect at the next wrap.
- `en`=0, effective next edge:
  - `cnt`←0, `duty`←0, FSM←IDLE.
  - Any in-flight read is discarded; `mem_ena`=0.
  - `mem_addr` and `next_sample` are held.
- On `en` re-asserting, the first period plays `duty`=0 and fetches the held `mem_addr`.
- Reset values: `cnt`=0, `duty`=0, `next_sample`=0, `mem_addr`=0, FSM=IDLE, `mem_ena`=0, `mem_wea`=0, `pwm_out`=0, `sample_tick`=0.
- Reset mid-fetch aborts the fetch; reset overrides `en`.

## Timing
- The READ cycle coincides with `cnt`=2044. Capture occurs on the edge ending cycle `cnt`=2044+RD_LAT, i.e. 2045 or 2046. Capture is therefore always complete before the wrap.
- `pwm_out` lags the compare by one register: high in the cycles where the previous cycle had `cnt` < `duty`.
- `sample_tick` is high during the cycle where `cnt`=0.
- Sample rate is `clk`/2048 (≈48.83 kHz at 100 MHz). Tone frequency = `step`·48.83 kHz/256.
- Exactly one `mem_ena` pulse per 2048 cycles while enabled; none while `en`=0.

## Configuration
- `SINE_PWM_COMPL_EN`: when defined, adds output port `pwm_out_n`, 1 bit. It is registered as the exact complement of `pwm_out` in the same cycle and resets to 1, so it is 1 during reset.
- When undefined, the port does not exist and `pwm_out` behaviour is unchanged.

## Test plan
- **Reset release.** Hold `resetn`=0 for 5 cycles, then release with `en`=1 and `step`=1. Expect:
  - all outputs 0 during reset;
  - first `mem_ena` at cycle 2044 after release, with `mem_addr`=0;
  - first period `pwm_out` constant 0.
- **Fetch and play.** LUT model with RD_LAT=1 returns 1024 at address 0. Expect:
  - `sample_tick` at cycle 2048;
  - then `pwm_out` high for exactly 1024 of the next 2048 cycles;
  - `mem_addr`=1.
- **Extremes and latency.** Samples 0 and 2047 give 0 and 2047 high cycles per period respectively. Repeat with RD_LAT=2: identical output.
- **Address wrap.** Set `step`=3 with `mem_addr`=254. Expect the next address to be 1, with no glitch on `mem_ena`.
- **Enable gating.** Drop `en` at `cnt`=2045 (mid-fetch). Expect:
  - no capture, and `pwm_out`=0 next cycle;
  - `mem_addr` held;
  - after re-enable, one duty-0 period, then the sample at the held address.
- **Complementary output.** With `SINE_PWM_COMPL_EN` defined, `pwm_out_n` = ~`pwm_out` on every cycle, including 1 during reset.
